// File: rtl/sm4_cbc_core_if.sv
// sm4_cbc_core_if -- handshake/bus bundle for the SM4 ECB/CBC core.
//   key_in/key_valid_in/key_ready_out : user key load and schedule status
//   iv_in/iv_valid_in                 : chain register load
//   mode_in/encdec_sel_in             : per-block CBC/ECB and enc/dec select
//   data_in/valid_in/ready_out        : block input handshake
//   result_out/result_valid_out/result_ready_in : block output handshake
// master = producer/consumer side, slave = the core.
interface sm4_cbc_core_if;
   logic [127:0] key_in;
   logic         key_valid_in;
   logic         key_ready_out;
   logic [127:0] iv_in;
   logic         iv_valid_in;
   logic         mode_in;
   logic         encdec_sel_in;
   logic [127:0] data_in;
   logic         valid_in;
   logic         ready_out;
   logic [127:0] result_out;
   logic         result_valid_out;
   logic         result_ready_in;

   modport master (
      output key_in, key_valid_in, iv_in, iv_valid_in, mode_in, encdec_sel_in,
             data_in, valid_in, result_ready_in,
      input  key_ready_out, ready_out, result_out, result_valid_out
   );
   modport slave (
      input  key_in, key_valid_in, iv_in, iv_valid_in, mode_in, encdec_sel_in,
             data_in, valid_in, result_ready_in,
      output key_ready_out, ready_out, result_out, result_valid_out
   );
endinterface

// File: rtl/sm4_cbc_core.sv
// sm4_cbc_core -- iterative SM4 block cipher with ECB/CBC chaining.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : sm4_cbc_core_if.slave (key load, IV load, block in/out)
// ROUNDS_PER_CYCLE rounds are chained combinationally per clock for both
// key expansion and data. The 32 round keys live in a register file and
// decryption walks it backwards via the round counter.

// SM4 byte substitution (combinational table).
module sm4_sbox (
   input  logic [7:0] i_x,
   output logic [7:0] o_y
);
   localparam logic [0:255][7:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};
   assign o_y = SBOX[i_x];
endmodule

// T (data, KEY_L=0) or T' (key schedule, KEY_L=1): tau followed by L / L'.
module sm4_tfun #(
   parameter bit KEY_L = 1'b0
) (
   input  logic [31:0] i_x,
   output logic [31:0] o_y
);
   logic [31:0] w_b;

   function automatic logic [31:0] rotl(input logic [31:0] b, input int n);
      return (b << n) | (b >> (32 - n));
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_sb
      sm4_sbox u_sbox (.i_x(i_x[8*g +: 8]), .o_y(w_b[8*g +: 8]));
   end

   if (KEY_L) begin : g_lk
      assign o_y = w_b ^ rotl(w_b, 13) ^ rotl(w_b, 23);
   end else begin : g_ld
      assign o_y = w_b ^ rotl(w_b, 2) ^ rotl(w_b, 10) ^ rotl(w_b, 18) ^ rotl(w_b, 24);
   end
endmodule

module sm4_cbc_core #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit CBC_EN           = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   sm4_cbc_core_if.slave   bus
);
   localparam int           R    = ROUNDS_PER_CYCLE;
   localparam logic [4:0]   LAST = 5'(32 - R);
   localparam logic [127:0] FK   = 128'ha3b1bac656aa3350677d9197b27022dc;

   typedef enum logic [1:0] {IDLE, KEYEXP, RUN, OUT} state_t;

   state_t              r_state, w_next;
   logic [4:0]          r_cnt;
   logic [31:0]         r_rk [32];
   // Word 0 holds X[i] / K[i]; packed [3:0] so r_x reads out as (X35..X32).
   logic [3:0][31:0]    r_k, r_x;
   logic [127:0]        r_chain, r_din, r_res;
   logic                r_res_vld, r_key_rdy, r_enc, r_cbc;
   logic                w_ready, w_accept, w_kload, w_last;
   logic [127:0]        w_chain;
   logic [R:0][3:0][31:0] w_ks, w_xs;
   logic [R-1:0][31:0]  w_knew;

   // Block word 0 is the most significant word of the 128-bit value.
   function automatic logic [3:0][31:0] wrev(input logic [127:0] d);
      return {d[31:0], d[63:32], d[95:64], d[127:96]};
   endfunction

   // CK[i] byte j = (4i+j)*7 mod 256, byte 0 most significant.
   function automatic logic [31:0] ck_word(input logic [4:0] i);
      ck_word = '0;
      for (int j = 0; j < 4; j++)
         ck_word[31-8*j -: 8] = 8'(({3'b0, i} * 8'd4 + 8'(j)) * 8'd7);
   endfunction

   assign w_last  = (r_cnt == LAST);
   // An IV arriving with the accepted block is the one that block chains on.
   assign w_chain = bus.iv_valid_in ? bus.iv_in : r_chain;
   assign w_ks[0] = r_k;
   assign w_xs[0] = r_x;

   for (genvar g = 0; g < R; g++) begin : g_rnd
      logic [4:0]  w_i;
      logic [31:0] w_rk, w_ck, w_tk, w_td;
      assign w_i  = r_cnt + 5'(g);
      assign w_ck = ck_word(w_i);
      assign w_rk = r_rk[r_enc ? w_i : 5'd31 - w_i];
      sm4_tfun #(.KEY_L(1'b1)) u_tk (
         .i_x(w_ks[g][1] ^ w_ks[g][2] ^ w_ks[g][3] ^ w_ck), .o_y(w_tk));
      sm4_tfun #(.KEY_L(1'b0)) u_td (
         .i_x(w_xs[g][1] ^ w_xs[g][2] ^ w_xs[g][3] ^ w_rk), .o_y(w_td));
      assign w_ks[g+1] = {w_ks[g][0] ^ w_tk, w_ks[g][3], w_ks[g][2], w_ks[g][1]};
      assign w_xs[g+1] = {w_xs[g][0] ^ w_td, w_xs[g][3], w_xs[g][2], w_xs[g][1]};
      assign w_knew[g] = w_ks[g+1][3];
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // FSM: next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_kload) w_next = KEYEXP;
                  else if (w_accept) w_next = RUN;
         KEYEXP:  if (w_last) w_next = IDLE;
         RUN:     if (w_last) w_next = OUT;
         OUT:     if (r_res_vld && bus.result_ready_in) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // FSM: outputs / strobes (key load beats a coincident data offer)
   always_comb begin
      w_kload  = (r_state == IDLE) && bus.key_valid_in;
      w_ready  = (r_state == IDLE) && r_key_rdy && !bus.key_valid_in;
      w_accept = w_ready && bus.valid_in;
   end

   assign bus.ready_out        = w_ready;
   assign bus.key_ready_out    = r_key_rdy;
   assign bus.result_out       = r_res;
   assign bus.result_valid_out = r_res_vld;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_k       <= '0;
         r_x       <= '0;
         r_chain   <= '0;
         r_din     <= '0;
         r_res     <= '0;
         r_res_vld <= 1'b0;
         r_key_rdy <= 1'b0;
         r_enc     <= 1'b0;
         r_cbc     <= 1'b0;
         for (int i = 0; i < 32; i++) r_rk[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.iv_valid_in) r_chain <= bus.iv_in;
               if (w_kload) begin
                  r_k       <= wrev(bus.key_in ^ FK);
                  r_cnt     <= '0;
                  r_key_rdy <= 1'b0;
               end else if (w_accept) begin
                  r_cnt <= '0;
                  r_enc <= bus.encdec_sel_in;
                  r_cbc <= CBC_EN && bus.mode_in;
                  r_din <= bus.data_in;
                  r_x   <= wrev(bus.data_in ^
                           ((CBC_EN && bus.mode_in && bus.encdec_sel_in) ? w_chain : '0));
               end
            end
            KEYEXP: begin
               for (int g = 0; g < R; g++) r_rk[r_cnt + 5'(g)] <= w_knew[g];
               r_k <= w_ks[R];
               if (w_last) r_key_rdy <= 1'b1;
               else        r_cnt     <= r_cnt + 5'(R);
            end
            RUN: begin
               r_x <= w_xs[R];
               if (!w_last) r_cnt <= r_cnt + 5'(R);
            end
            OUT: begin
               // First OUT cycle finalises the result and the chain value.
               if (!r_res_vld) begin
                  r_res_vld <= 1'b1;
                  r_res     <= (r_cbc && !r_enc) ? (r_x ^ r_chain) : r_x;
                  if (r_cbc) r_chain <= r_enc ? r_x : r_din;
               end else if (bus.result_ready_in) begin
                  r_res_vld <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
